// File: rtl/acc_io_pkg.sv
// Shared definitions for the accumulator I/O blocks (output reader and IOIn writer).
package acc_io_pkg;

  // Width of the accumulator Output / IOIn data ports.
  localparam int ACC_WIDTH      = 16;

  // Default capture FIFO depth; must be a power of two and at least 2.
  localparam int ACC_FIFO_DEPTH = 8;

  // Capture mode encodings for the CHANGE_MODE parameter.
  localparam int MODE_STROBE    = 0;  // capture on every acc_out_we pulse
  localparam int MODE_CHANGE    = 1;  // capture whenever acc_out differs from the last sample

  // Occupancy counter width: one bit more than the pointers so full and empty differ.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acc_output_reader_if.sv
// Bus between the accumulator output side, the reader and the consuming host.
//
// Handshake: rd_valid means rd_data holds the FIFO head. A word is transferred
// at a rising CLK edge where rd_valid && rd_ready are both 1. rd_ready may be
// asserted at any time, and it is ignored while rd_valid=0. rd_data does not
// change while rd_valid=1 and rd_ready=0.
interface acc_output_reader_if
  import acc_io_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = ACC_FIFO_DEPTH
);

  // Accumulator side
  logic [WIDTH-1:0]          acc_out;
  logic                      acc_out_we;

  // Consumer side
  logic [WIDTH-1:0]          rd_data;
  logic                      rd_valid;
  logic                      rd_ready;

  // Status / control
  logic [count_width(DEPTH)-1:0] count;
  logic                      overflow;
  logic                      clr_ovf;

  // Host or bench: drives the accumulator output and consumes the FIFO.
  modport master (
    output acc_out, acc_out_we, rd_ready, clr_ovf,
    input  rd_data, rd_valid, count, overflow
  );

  // Reader block.
  modport slave (
    input  acc_out, acc_out_we, rd_ready, clr_ovf,
    output rd_data, rd_valid, count, overflow
  );

endinterface

// File: rtl/acc_sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module acc_sync_fifo
  import acc_io_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = ACC_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          empty,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: pop only when something is stored, push only when a slot is or becomes free.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != DEPTH_CNT) || do_pop);
  end

  // Storage; cleared on reset so the head reads 0 after reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; the counter tracks occupancy 0..DEPTH.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head read and status flags.
  always_comb begin
    dout  = mem[rd_ptr];
    empty = (cnt == '0);
    full  = (cnt == DEPTH_CNT);
    count = cnt;
  end

endmodule

// File: rtl/acc_output_reader.sv
// Captures each new accumulator Output value into a FIFO and drains it to a
// consumer over a valid/ready handshake. Drops are recorded in a sticky flag.
module acc_output_reader
  import acc_io_pkg::*;
#(
  parameter int WIDTH       = ACC_WIDTH,
  parameter int DEPTH       = ACC_FIFO_DEPTH,
  parameter int CHANGE_MODE = MODE_CHANGE
) (
  input  logic               CLK,
  input  logic               reset,
  acc_output_reader_if.slave bus
);

  logic [WIDTH-1:0]              prev;
  logic                          overflow_q;
  logic                          evt;
  logic                          pop_ok;
  logic                          push_ok;
  logic                          drop;
  logic [WIDTH-1:0]              fifo_dout;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic [count_width(DEPTH)-1:0] fifo_count;

  // Event detection and push/pop/drop decisions for this cycle.
  always_comb begin
    if (CHANGE_MODE == MODE_CHANGE) begin
      evt = (bus.acc_out != prev);
    end else begin
      evt = bus.acc_out_we;
    end
    pop_ok  = !fifo_empty && bus.rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok = evt && (!fifo_full || pop_ok);
    drop    = evt && fifo_full && !pop_ok;
  end

  // Last sampled accumulator value; updated every cycle, so a dropped value is not retried.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      prev <= '0;
    end else begin
      prev <= bus.acc_out;
    end
  end

  // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  acc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (bus.acc_out),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Consumer-facing outputs.
  always_comb begin
    bus.rd_data  = fifo_dout;
    bus.rd_valid = !fifo_empty;
    bus.count    = fifo_count;
    bus.overflow = overflow_q;
  end

endmodule

// File: tb/tb_acc_output_reader.sv
// Directed bench for acc_output_reader: one instance in change mode, one in strobe mode.
module tb_acc_output_reader;
  import acc_io_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  logic CLK = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  acc_output_reader_if #(.WIDTH(W), .DEPTH(D)) chg_if ();
  acc_output_reader_if #(.WIDTH(W), .DEPTH(D)) stb_if ();

  acc_output_reader #(.WIDTH(W), .DEPTH(D), .CHANGE_MODE(MODE_CHANGE)) u_chg (
    .CLK   (CLK),
    .reset (reset),
    .bus   (chg_if)
  );

  acc_output_reader #(.WIDTH(W), .DEPTH(D), .CHANGE_MODE(MODE_STROBE)) u_stb (
    .CLK   (CLK),
    .reset (reset),
    .bus   (stb_if)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_chg(input logic [W-1:0] v);
    chg_if.acc_out = v;
    tick();
  endtask

  // Check the head against exp, then pop it in one handshake cycle.
  task automatic pop_exp(input bit use_stb, input string tag, input logic [W-1:0] exp);
    if (use_stb) begin
      check_eq({tag, "_valid"}, 32'(stb_if.rd_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(stb_if.rd_data), 32'(exp));
      stb_if.rd_ready = 1'b1;
      tick();
      stb_if.rd_ready = 1'b0;
    end else begin
      check_eq({tag, "_valid"}, 32'(chg_if.rd_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(chg_if.rd_data), 32'(exp));
      chg_if.rd_ready = 1'b1;
      tick();
      chg_if.rd_ready = 1'b0;
    end
  endtask

  // Scoreboard drain: pop everything queued, in order.
  task automatic drain(input bit use_stb, input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_exp(use_stb, tag, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset             = 1'b0;
    chg_if.acc_out    = 16'd12;
    chg_if.acc_out_we = 1'b0;
    chg_if.rd_ready   = 1'b0;
    chg_if.clr_ovf    = 1'b0;
    stb_if.acc_out    = 16'd0;
    stb_if.acc_out_we = 1'b0;
    stb_if.rd_ready   = 1'b0;
    stb_if.clr_ovf    = 1'b0;

    // Reset held 3 cycles with acc_out=12.
    repeat (3) tick();
    check_eq("rst_data", 32'(chg_if.rd_data), 32'd0);
    reset = 1'b1;
    check_eq("rst_valid", 32'(chg_if.rd_valid), 32'd0);
    check_eq("rst_count", 32'(chg_if.count), 32'd0);
    check_eq("rst_ovf", 32'(chg_if.overflow), 32'd0);
    check_eq("rst_stb_count", 32'(stb_if.count), 32'd0);
    tick();
    check_eq("first_count", 32'(chg_if.count), 32'd1);
    pop_exp(1'b0, "first", 16'd12);
    check_eq("first_empty", 32'(chg_if.count), 32'd0);

    // Empty: rd_ready ignored, no pass-through of a same-cycle capture.
    chg_if.rd_ready = 1'b1;
    tick();
    check_eq("empty_ready_count", 32'(chg_if.count), 32'd0);
    chg_if.acc_out = 16'd40;
    tick();
    chg_if.rd_ready = 1'b0;
    check_eq("nopass_count", 32'(chg_if.count), 32'd1);
    pop_exp(1'b0, "nopass", 16'd40);

    // Change capture: 2,2,3,5,5,7 -> 2,3,5,7.
    set_chg(16'd2);
    set_chg(16'd2);
    set_chg(16'd3);
    set_chg(16'd5);
    set_chg(16'd5);
    set_chg(16'd7);
    check_eq("chg_count", 32'(chg_if.count), 32'd4);
    tick();
    check_eq("chg_hold_data", 32'(chg_if.rd_data), 32'd2);
    check_eq("chg_hold_count", 32'(chg_if.count), 32'd4);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd7);
    drain(1'b0, "chg");
    check_eq("chg_drained", 32'(chg_if.count), 32'd0);

    // Strobe mode: three pulses with 11 held, then a change without strobe.
    stb_if.acc_out = 16'd11;
    repeat (3) begin
      stb_if.acc_out_we = 1'b1;
      tick();
      stb_if.acc_out_we = 1'b0;
      tick();
    end
    check_eq("stb_count", 32'(stb_if.count), 32'd3);
    stb_if.acc_out = 16'd9;
    tick();
    check_eq("stb_nochange_count", 32'(stb_if.count), 32'd3);
    exp_q.push_back(16'd11);
    exp_q.push_back(16'd11);
    exp_q.push_back(16'd11);
    drain(1'b1, "stb");
    check_eq("stb_drained", 32'(stb_if.count), 32'd0);

    // Full/overflow: 9 distinct values, the 9th dropped.
    for (int i = 0; i < 9; i++) begin
      set_chg(16'(20 + i));
    end
    check_eq("full_count", 32'(chg_if.count), 32'd8);
    check_eq("full_ovf", 32'(chg_if.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(20 + i));
    end
    drain(1'b0, "full");
    check_eq("full_drained", 32'(chg_if.count), 32'd0);
    check_eq("ovf_sticky", 32'(chg_if.overflow), 32'd1);
    chg_if.clr_ovf = 1'b1;
    tick();
    chg_if.clr_ovf = 1'b0;
    check_eq("ovf_clr", 32'(chg_if.overflow), 32'd0);
    check_eq("ovf_clr_count", 32'(chg_if.count), 32'd0);

    // Full plus simultaneous pop and push of 13.
    for (int i = 0; i < 8; i++) begin
      set_chg(16'(30 + i));
    end
    check_eq("refill_count", 32'(chg_if.count), 32'd8);
    chg_if.rd_ready = 1'b1;
    chg_if.acc_out  = 16'd13;
    tick();
    chg_if.rd_ready = 1'b0;
    check_eq("pp_count", 32'(chg_if.count), 32'd8);
    check_eq("pp_ovf", 32'(chg_if.overflow), 32'd0);
    check_eq("pp_head", 32'(chg_if.rd_data), 32'd31);

    // Drop in the same cycle as clr_ovf: set wins.
    chg_if.acc_out = 16'd14;
    chg_if.clr_ovf = 1'b1;
    tick();
    chg_if.clr_ovf = 1'b0;
    check_eq("setwins_ovf", 32'(chg_if.overflow), 32'd1);
    check_eq("setwins_count", 32'(chg_if.count), 32'd8);
    chg_if.clr_ovf = 1'b1;
    tick();
    chg_if.clr_ovf = 1'b0;
    check_eq("setwins_clr", 32'(chg_if.overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(16'(30 + i));
    end
    exp_q.push_back(16'd13);
    drain(1'b0, "pp");
    check_eq("pp_drained", 32'(chg_if.count), 32'd0);

    // Mid-operation asynchronous reset with 5 entries stored.
    for (int i = 0; i < 5; i++) begin
      set_chg(16'(50 + i));
    end
    check_eq("mid_count", 32'(chg_if.count), 32'd5);
    reset          = 1'b0;
    chg_if.acc_out = 16'd17;
    #1;
    check_eq("mid_rst_count", 32'(chg_if.count), 32'd0);
    check_eq("mid_rst_valid", 32'(chg_if.rd_valid), 32'd0);
    check_eq("mid_rst_ovf", 32'(chg_if.overflow), 32'd0);
    #4;
    reset = 1'b1;
    tick();
    check_eq("post_rst_count", 32'(chg_if.count), 32'd1);
    pop_exp(1'b0, "post_rst", 16'd17);
    check_eq("post_rst_drained", 32'(chg_if.count), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
